// File: rtl/vga_sync_if.sv
// Raster timing bundle produced by vga_sync_gen and consumed by the pixel-colour renderers.
interface vga_sync_if;
    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       pix_tick;
    logic       frame_start;

    modport master (
        output hcnt, vcnt, hsync, vsync, video_on, pix_tick, frame_start
    );

    modport slave (
        input hcnt, vcnt, hsync, vsync, video_on, pix_tick, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-tick divider, h/v counters, registered sync/video flags.
// Define VGA_SYNC_POS_EN for active-high hsync/vsync (default is active-low).
module vga_sync_gen #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst,
    vga_sync_if.master  vga
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

`ifdef VGA_SYNC_POS_EN
    localparam logic SYNC_ON = 1'b1;
`else
    localparam logic SYNC_ON = 1'b0;
`endif

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic [9:0]       hcnt_q, hcnt_d;
    logic [9:0]       vcnt_q, vcnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_q, video_d;
    logic             frame_q, frame_d;

    always_comb begin
        div_d   = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        tick_d  = (div_q == DIV_LAST);
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        frame_d = 1'b0;
        if (tick_q) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                if (vcnt_q == V_LAST) begin
                    vcnt_d  = '0;
                    frame_d = 1'b1;
                end else begin
                    vcnt_d = vcnt_q + 10'd1;
                end
            end else begin
                hcnt_d = hcnt_q + 10'd1;
            end
        end
        // Flags decode the next counter values so they change on the same edge as the counters.
        hsync_d = (hcnt_d >= H_SYNC_BEG && hcnt_d <= H_SYNC_END) ? SYNC_ON : ~SYNC_ON;
        vsync_d = (vcnt_d >= V_SYNC_BEG && vcnt_d <= V_SYNC_END) ? SYNC_ON : ~SYNC_ON;
        video_d = (hcnt_d < H_ACT) && (vcnt_d < V_ACT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            tick_q  <= 1'b0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            hsync_q <= ~SYNC_ON;
            vsync_q <= ~SYNC_ON;
            video_q <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            tick_q  <= tick_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            video_q <= video_d;
            frame_q <= frame_d;
        end
    end

    assign vga.hcnt        = hcnt_q;
    assign vga.vcnt        = vcnt_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = video_q;
    assign vga.pix_tick    = tick_q;
    assign vga.frame_start = frame_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing, reduced-timing and CLK_DIV=1 instances against a
// closed-form raster model indexed by clocks since reset release.
module tb_vga_sync_gen;
`ifdef VGA_SYNC_POS_EN
    localparam logic SYNC_ON = 1'b1;
`else
    localparam logic SYNC_ON = 1'b0;
`endif

    typedef logic [24:0] vec_t;
    typedef logic [74:0] all_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   k = -1;      // clocks since reset release; -1 while in reset
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) k <= rst ? -1 : k + 1;

    vga_sync_if vif_def ();
    vga_sync_if vif_sm ();
    vga_sync_if vif_d1 ();

    vga_sync_gen u_def (.clk(clk), .rst(rst), .vga(vif_def));

    vga_sync_gen #(
        .CLK_DIV(3), .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_sm (.clk(clk), .rst(rst), .vga(vif_sm));

    vga_sync_gen #(
        .CLK_DIV(1), .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_d1 (.clk(clk), .rst(rst), .vga(vif_d1));

    // Pixel n = floor(kk/dv) since release; raster position is n mod the frame size.
    function automatic vec_t model(input int kk, input int dv, input int ha, input int hf,
                                   input int hs, input int hb, input int va, input int vf,
                                   input int vs, input int vb);
        int ht, vt, n, p, h, v;
        logic hsa, vsa, vo, pt, fs;
        if (kk < 0) return {10'd0, 10'd0, ~SYNC_ON, ~SYNC_ON, 3'b000};
        ht  = ha + hf + hs + hb;
        vt  = va + vf + vs + vb;
        n   = kk / dv;
        p   = n % (ht * vt);
        h   = p % ht;
        v   = p / ht;
        hsa = (h >= ha + hf) && (h < ha + hf + hs);
        vsa = (v >= va + vf) && (v < va + vf + vs);
        vo  = (h < ha) && (v < va);
        pt  = (kk % dv) == dv - 1;
        fs  = (n > 0) && (p == 0) && (kk % dv == 0);
        return {10'(h), 10'(v), hsa ? SYNC_ON : ~SYNC_ON, vsa ? SYNC_ON : ~SYNC_ON, vo, pt, fs};
    endfunction

    function automatic vec_t exp_def();
        return model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction
    function automatic vec_t exp_sm();
        return model(k, 3, 16, 4, 6, 4, 8, 2, 2, 3);
    endfunction
    function automatic vec_t exp_d1();
        return model(k, 1, 16, 4, 6, 4, 8, 2, 2, 3);
    endfunction

    function automatic vec_t obs_def();
        return {vif_def.hcnt, vif_def.vcnt, vif_def.hsync, vif_def.vsync,
                vif_def.video_on, vif_def.pix_tick, vif_def.frame_start};
    endfunction
    function automatic vec_t obs_sm();
        return {vif_sm.hcnt, vif_sm.vcnt, vif_sm.hsync, vif_sm.vsync,
                vif_sm.video_on, vif_sm.pix_tick, vif_sm.frame_start};
    endfunction
    function automatic vec_t obs_d1();
        return {vif_d1.hcnt, vif_d1.vcnt, vif_d1.hsync, vif_d1.vsync,
                vif_d1.video_on, vif_d1.pix_tick, vif_d1.frame_start};
    endfunction

    task automatic test_reset();
        all_t o, e;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            o = {obs_def(), obs_sm(), obs_d1()};
            e = {exp_def(), exp_sm(), exp_d1()};
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL reset_hold: got %h expected %h", o, e);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            o = {obs_def(), obs_sm(), obs_d1()};
            e = {exp_def(), exp_sm(), exp_d1()};
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL reset_release k=%0d: got %h expected %h", k, o, e);
            end
        end
    endtask

    task automatic test_line_timing();
        vec_t o, e;
        int hs_clks = 0;
        for (int i = 0; i < 6500; i++) begin
            @(negedge clk);
            o = obs_def();
            e = exp_def();
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL line_timing k=%0d: got %h expected %h", k, o, e);
            end
            if (vif_def.vcnt == 10'd0 && vif_def.hsync == SYNC_ON) hs_clks++;
        end
        n_vec++;
        if (hs_clks !== 384) begin
            n_err++;
            $display("FAIL hsync_width: got %0d clks expected 384", hs_clks);
        end
    endtask

    task automatic test_frame_wrap();
        vec_t o, e;
        int pulses = 0, last = -1, vs_clks = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            o = obs_sm();
            e = exp_sm();
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL frame_wrap k=%0d: got %h expected %h", k, o, e);
            end
            if (vif_sm.frame_start === 1'b1) begin
                if (last >= 0) begin
                    n_vec++;
                    if (k - last !== 1350) begin
                        n_err++;
                        $display("FAIL frame_period: got %0d expected 1350", k - last);
                    end
                end
                last = k;
                pulses++;
            end
            if (pulses == 1 && vif_sm.vsync === SYNC_ON) vs_clks++;
        end
        n_vec++;
        if (pulses < 2) begin
            n_err++;
            $display("FAIL frame_pulses: got %0d expected at least 2", pulses);
        end else if (vs_clks !== 180) begin
            n_err++;
            $display("FAIL vsync_width: got %0d clks expected 180", vs_clks);
        end
    endtask

    task automatic test_clk_div1();
        vec_t o, e;
        int last = -1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            o = obs_d1();
            e = exp_d1();
            n_vec++;
            if (o !== e || vif_d1.pix_tick !== 1'b1) begin
                n_err++;
                $display("FAIL clk_div1 k=%0d: got %h expected %h", k, o, e);
            end
            if (vif_d1.frame_start === 1'b1) begin
                if (last >= 0) begin
                    n_vec++;
                    if (k - last !== 450) begin
                        n_err++;
                        $display("FAIL div1_period: got %0d expected 450", k - last);
                    end
                end
                last = k;
            end
        end
    endtask

    task automatic test_mid_frame_reset();
        vec_t o, e;
        bit found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (vif_sm.hcnt == 10'd23 && vif_sm.vcnt == 10'd11) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL mid_reset_reach: got no hcnt=23/vcnt=11 expected within 3000 clks");
            return;
        end
        n_vec++;
        if (vif_sm.hsync !== SYNC_ON || vif_sm.vsync !== SYNC_ON) begin
            n_err++;
            $display("FAIL mid_reset_syncs: got %b%b expected %b%b",
                     vif_sm.hsync, vif_sm.vsync, SYNC_ON, SYNC_ON);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        o = obs_sm();
        e = {10'd0, 10'd0, ~SYNC_ON, ~SYNC_ON, 3'b000};
        n_vec++;
        if (o !== e) begin
            n_err++;
            $display("FAIL mid_reset_state: got %h expected %h", o, e);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            o = obs_sm();
            e = exp_sm();
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL mid_reset_restart k=%0d: got %h expected %h", k, o, e);
            end
        end
    endtask

    task automatic test_random_reset();
        all_t o, e;
        int run, hold;
        for (int it = 0; it < 6; it++) begin
            run  = int'($urandom_range(3000, 1));
            hold = int'($urandom_range(3, 1));
            for (int i = 0; i < run + hold; i++) begin
                rst = (i >= run);
                @(negedge clk);
                o = {obs_def(), obs_sm(), obs_d1()};
                e = {exp_def(), exp_sm(), exp_d1()};
                n_vec++;
                if (o !== e) begin
                    n_err++;
                    $display("FAIL random_reset it=%0d k=%0d: got %h expected %h", it, k, o, e);
                end
            end
            rst = 1'b0;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            o = {obs_def(), obs_sm(), obs_d1()};
            e = {exp_def(), exp_sm(), exp_d1()};
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL random_release k=%0d: got %h expected %h", k, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frame_wrap();
        test_clk_div1();
        test_mid_frame_reset();
        test_random_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates the VGA raster timing that drives the pixel-colour renderers: horizontal/vertical pixel counters, sync pulses and active-video flag.
- Its hcnt/vcnt outputs are the scan coordinates consumed by every shape/colour block downstream.
- Default timing is 640x480 @ 60 Hz, derived from the system clock by an integer pixel-tick divider.

Parameters:
- CLK_DIV, 4, system clocks per pixel (>=1); 100 MHz / 4 = 25 MHz pixel rate
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk, input, 1, system clock; all logic is on the rising edge
- rst, input, 1, synchronous reset, active-high
- hcnt, output, 10, horizontal pixel counter, 0..H_TOTAL-1
- vcnt, output, 10, vertical line counter, 0..V_TOTAL-1
- hsync, output, 1, horizontal sync, active-low by default
- vsync, output, 1, vertical sync, active-low by default
- video_on, output, 1, high when hcnt<H_ACTIVE and vcnt<V_ACTIVE
- pix_tick, output, 1, one-clk strobe marking each pixel period
- frame_start, output, 1, one-clk pulse when the raster returns to (0,0)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800. V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
- Divider:
  - div counter runs 0..CLK_DIV-1 and wraps.
  - pix_tick is registered and high for exactly one clk when div==CLK_DIV-1.
  - With CLK_DIV=1, pix_tick is high every clk after reset.
- Horizontal counter:
  - On each clk where pix_tick is high, hcnt increments.
  - hcnt==H_TOTAL-1 wraps to 0.
- Vertical counter:
  - vcnt increments only on a tick where hcnt wraps.
  - vcnt==V_TOTAL-1 with hcnt wrap gives vcnt=0.
  - hcnt and vcnt update on the same edge.
- hsync, vsync, video_on and frame_start are flops, decoded from next-state counter values, so they are always aligned with the current hcnt/vcnt (no combinational glitches).
- hsync is active for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = 656..751.
- vsync is active for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = 490..491.
  - vsync changes on the same edge as vcnt, i.e. at hcnt=0.
- frame_start is high for the single clk during which hcnt==0 and vcnt==0 first appear after a wrap.
  - It is not asserted out of reset.
- Reset (rst high at a clk edge):
  - div=0, hcnt=0, vcnt=0, pix_tick=0, frame_start=0, video_on=0.
  - hsync and vsync take their inactive levels (1 by default).
  - A reset mid-frame or mid-sync restarts the raster immediately at the next edge.
- After rst falls:
  - The first edge sets video_on=1 (counters at 0,0).
  - The first pix_tick occurs CLK_DIV clks after reset release.
- Widths:
  - Counters are 10 bits; H_TOTAL-1 and V_TOTAL-1 must be <1024.
  - Parameter sets violating this are unsupported.
  - No saturation: wrap only at the totals.

Optional Feature:
- Macro VGA_SYNC_POS_EN.
- Defined:
  - hsync/vsync are active-high inside their sync windows.
  - Both reset to 0.
- Undefined (default):
  - hsync/vsync are active-low inside their sync windows.
  - Both reset to 1.
- No other behaviour changes.

Test Plan:
- Reset release, default params:
  - hcnt=0, vcnt=0, hsync=1, vsync=1, video_on=1 after the first edge.
  - pix_tick pulses every 4 clks; first pulse 4 clks after release.
- Line timing:
  - hcnt 639->640 drops video_on.
  - hsync is low from hcnt=656 through 751: exactly 96 ticks / 384 clks.
  - hcnt 799->0 increments vcnt.
- Frame wrap:
  - At vcnt=524, hcnt=799 plus a tick, both go to 0 and frame_start is high for 1 clk.
  - Frame period is 800*525*4 = 1,680,000 clks.
  - vsync is low for vcnt 490..491 (1600 ticks).
- Mid-frame reset:
  - Assert rst for 1 clk at hcnt=700, vcnt=491 (both syncs active).
  - Next edge gives hcnt=0, vcnt=0, hsync=1, vsync=1, pix_tick=0, frame_start=0.
- CLK_DIV=1 build:
  - pix_tick is high every clk after release.
  - hcnt advances each clk; frame period is 420,000 clks.
- VGA_SYNC_POS_EN defined:
  - hsync reads 1 for hcnt 656..751 and 0 elsewhere.
  - Reset value of hsync/vsync is 0.
